// File: rtl/tdc_channel_cfg_reg_pkg.sv
// TDC channel config register stage: shared types and constants.
// Optional build macro TDC_CFG_TIMEOUT_EN is consumed by the FSM.
package TDCCfgPackage;

  localparam int unsigned ACT_WIDTH  = 17;
  localparam int unsigned MASTER_BIT = 16;

  localparam logic [3:0] ADDR_ACTIVATE = 4'h0;
  localparam logic [3:0] ADDR_STATUS   = 4'h1;
  localparam logic [3:0] ADDR_CTRL     = 4'h2;

  localparam int unsigned CTRL_RENOTIFY = 0;
  localparam int unsigned CTRL_CLR_ERR  = 1;

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_NOTIFY = 2'd1,
    CFG_ACK    = 2'd2
  } cfg_state_t;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  commit_cnt;
    logic [5:0]  rsvd_lo;
    logic        err;
    logic        dirty;
  } status_t;

  // Writable bits of ACTIVATE: master enable plus
  // one bit per implemented channel.
  function automatic logic [ACT_WIDTH-1:0] act_mask(
    input int unsigned n
  );
    logic [ACT_WIDTH-1:0] m;
    m = '0;
    m[MASTER_BIT] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tdc_channel_cfg_reg_if.sv
// Host register bus plus consumer handshake for the
// TDC channel config register stage.
interface tdc_channel_cfg_reg_if
  import TDCCfgPackage::*;
;

  logic                 reg_wr;
  logic                 reg_rd;
  logic [3:0]           reg_addr;
  logic [31:0]          reg_wdata;
  logic [31:0]          reg_rdata;
  logic                 reg_rvalid;
  logic                 channel_changed;
  logic                 read_active_channel;
  logic                 read_ack;
  logic [ACT_WIDTH-1:0] activate_channels;

  modport master (
    output reg_wr,
    output reg_rd,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata,
    input  reg_rvalid,
    input  channel_changed,
    output read_active_channel,
    input  read_ack,
    input  activate_channels
  );

  modport slave (
    input  reg_wr,
    input  reg_rd,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata,
    output reg_rvalid,
    output channel_changed,
    input  read_active_channel,
    output read_ack,
    output activate_channels
  );

endinterface

// File: rtl/tdc_channel_cfg_reg_fsm.sv
// Notify/commit handshake toward the channel-enable block.
// TDC_CFG_TIMEOUT_EN adds a sticky NOTIFY timeout error.
module tdc_cfg_handshake_fsm
  import TDCCfgPackage::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_dirty_i,
  input  logic                 clr_err_i,
  input  logic                 req_i,
  input  logic [ACT_WIDTH-1:0] shadow_i,
  output logic                 dirty_o,
  output logic                 err_o,
  output logic                 changed_o,
  output logic                 ack_o,
  output logic [ACT_WIDTH-1:0] active_o,
  output logic [7:0]           cnt_o
);

  localparam logic [1:0] ST_IDLE   = CFG_IDLE;
  localparam logic [1:0] ST_NOTIFY = CFG_NOTIFY;
  localparam logic [1:0] ST_ACK    = CFG_ACK;

  logic [1:0]           state_q, state_d;
  logic                 dirty_q, dirty_d;
  logic                 changed_q, changed_d;
  logic                 ack_q, ack_d;
  logic [ACT_WIDTH-1:0] active_q, active_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 commit;

  assign commit = (state_q == ST_NOTIFY) && req_i;

  // Next-state: a host write landing on the commit
  // edge keeps dirty set so a fresh notify follows.
  always_comb begin
    state_d   = state_q;
    changed_d = changed_q;
    ack_d     = 1'b0;
    active_d  = active_q;
    cnt_d     = cnt_q;
    dirty_d   = set_dirty_i | (dirty_q & ~commit);
    unique case (state_q)
      ST_IDLE: begin
        if (dirty_q) begin
          state_d   = ST_NOTIFY;
          changed_d = 1'b1;
        end
      end
      ST_NOTIFY: begin
        if (req_i) begin
          state_d   = ST_ACK;
          active_d  = shadow_i;
          ack_d     = 1'b1;
          changed_d = 1'b0;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      ST_ACK: begin
        if (dirty_q) begin
          state_d   = ST_NOTIFY;
          changed_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        changed_d = 1'b0;
      end
    endcase
  end

  // Handshake state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      dirty_q   <= 1'b0;
      changed_q <= 1'b0;
      ack_q     <= 1'b0;
      active_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dirty_q   <= dirty_d;
      changed_q <= changed_d;
      ack_q     <= ack_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef TDC_CFG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Count cycles stuck in NOTIFY; saturate so a
  // cleared error is not immediately re-raised.
  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q & ~clr_err_i;
    if ((state_q == ST_NOTIFY) && !req_i) begin
      if (tmo_q != TMO_MAX) begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_HIT) err_d = 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_clr;
  assign unused_clr = clr_err_i;
  assign err_o      = 1'b0;
`endif

  assign dirty_o   = dirty_q;
  assign changed_o = changed_q;
  assign ack_o     = ack_q;
  assign active_o  = active_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/tdc_channel_cfg_reg.sv
// Host-facing shadow/commit register for TDC channel enables.
// Define TDC_CFG_TIMEOUT_EN to enable the NOTIFY timeout error.
module tdc_channel_cfg_reg
  import TDCCfgPackage::*;
#(
  parameter int unsigned CHANNEL_COUNT  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  tdc_channel_cfg_reg_if.slave bus
);

  localparam logic [ACT_WIDTH-1:0] WMASK =
    act_mask(CHANNEL_COUNT);

  logic [ACT_WIDTH-1:0] shadow_q, shadow_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rvalid_q;

  logic       wr_act, wr_ctrl;
  logic       rd_act, rd_sts;
  logic       set_dirty, clr_err;
  logic       dirty, err;
  logic [7:0] cnt;
  status_t    sts;

  logic [14:0] unused_wdata;
  assign unused_wdata = bus.reg_wdata[31:17];

  assign wr_act  = bus.reg_wr &&
                   (bus.reg_addr == ADDR_ACTIVATE);
  assign wr_ctrl = bus.reg_wr &&
                   (bus.reg_addr == ADDR_CTRL);
  assign rd_act  = bus.reg_addr == ADDR_ACTIVATE;
  assign rd_sts  = bus.reg_addr == ADDR_STATUS;

  assign set_dirty = wr_act |
    (wr_ctrl & bus.reg_wdata[CTRL_RENOTIFY]);
  assign clr_err   = wr_ctrl &
    bus.reg_wdata[CTRL_CLR_ERR];

  // Shadow takes masked host data on ACTIVATE writes.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_act) begin
      shadow_d = bus.reg_wdata[ACT_WIDTH-1:0] & WMASK;
    end
  end

  // Read mux samples pre-write state, so a same-cycle
  // write is not visible to the read.
  always_comb begin
    sts            = '0;
    sts.commit_cnt = cnt;
    sts.err        = err;
    sts.dirty      = dirty;
    rdata_d        = rdata_q;
    if (bus.reg_rd) begin
      unique case (1'b1)
        rd_act:  rdata_d = 32'(shadow_q);
        rd_sts:  rdata_d = sts;
        default: rdata_d = '0;
      endcase
    end
  end

  // Shadow word and registered host readback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      rvalid_q <= bus.reg_rd;
    end
  end

  tdc_cfg_handshake_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .set_dirty_i (set_dirty),
    .clr_err_i   (clr_err),
    .req_i       (bus.read_active_channel),
    .shadow_i    (shadow_q),
    .dirty_o     (dirty),
    .err_o       (err),
    .changed_o   (bus.channel_changed),
    .ack_o       (bus.read_ack),
    .active_o    (bus.activate_channels),
    .cnt_o       (cnt)
  );

  assign bus.reg_rdata  = rdata_q;
  assign bus.reg_rvalid = rvalid_q;

endmodule

// File: tb/tb_tdc_channel_cfg_reg.sv
// Randomized self-checking bench for tdc_channel_cfg_reg.
// Honours TDC_CFG_TIMEOUT_EN for the timeout scenario.
module tb_tdc_channel_cfg_reg;

  localparam int unsigned CH  = 2;
  localparam int unsigned TMO = 16;
  localparam logic [16:0] MASK =
    17'h10000 | 17'((1 << CH) - 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [16:0] exp_shadow;
  logic [7:0]  exp_cnt;

  tdc_channel_cfg_reg_if bus();

  tdc_channel_cfg_reg #(
    .CHANNEL_COUNT  (CH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d);
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    cyc();
    bus.reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a,
                    output logic v,
                    output logic [31:0] d);
    bus.reg_rd   = 1'b1;
    bus.reg_addr = a;
    cyc();
    bus.reg_rd = 1'b0;
    v = bus.reg_rvalid;
    d = bus.reg_rdata;
  endtask

  task automatic wait_cc(input int max, output logic seen);
    seen = 1'b0;
    for (int i = 0; i <= max; i++) begin
      if (bus.channel_changed === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (i < max) cyc();
    end
  endtask

  task automatic take(output logic ack, output logic cc,
                      output logic [16:0] w,
                      output logic ack2);
    bus.read_active_channel = 1'b1;
    cyc();
    bus.read_active_channel = 1'b0;
    ack  = bus.read_ack;
    cc   = bus.channel_changed;
    w    = bus.activate_channels;
    cyc();
    ack2 = bus.read_ack;
  endtask

  task automatic test_reset();
    logic v;
    logic [31:0] d;
    reset = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if ({bus.channel_changed, bus.read_ack,
         bus.reg_rvalid, bus.activate_channels,
         bus.reg_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got cc=%b ack=%b rv=%b act=%h rd=%h exp all 0",
        bus.channel_changed, bus.read_ack, bus.reg_rvalid,
        bus.activate_channels, bus.reg_rdata);
    end
    reset = 1'b1;
    exp_shadow = '0;
    exp_cnt    = '0;
    rd(4'h1, v, d);
    n_cmp++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_status: got v=%b d=%h exp 1/0", v, d);
    end
    rd(4'h0, v, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_activate: got %h exp 0", d);
    end
  endtask

  task automatic test_basic();
    logic ack, cc, ack2, v;
    logic [16:0] w;
    logic [31:0] d;
    wr(4'h0, 32'h3);
    exp_shadow = 17'h3;
    repeat (3) cyc();
    n_cmp++;
    if (bus.channel_changed !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_cc: got %b exp 1", bus.channel_changed);
    end
    take(ack, cc, w, ack2);
    exp_cnt++;
    n_cmp++;
    if (ack !== 1'b1 || cc !== 1'b0 || w !== 17'h3) begin
      n_bad++;
      $display("FAIL basic_commit: got ack=%b cc=%b w=%h exp 1/0/00003",
        ack, cc, w);
    end
    n_cmp++;
    if (ack2 !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ack_pulse: got %b exp 0", ack2);
    end
    rd(4'h1, v, d);
    n_cmp++;
    if (d[15:8] !== exp_cnt || d[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_status: got %h exp cnt=%h dirty=0", d, exp_cnt);
    end
  endtask

  task automatic test_mask();
    logic ack, cc, ack2, v, seen;
    logic [16:0] w;
    logic [31:0] d;
    wr(4'h0, 32'h1FFFF);
    exp_shadow = 17'h1FFFF & MASK;
    rd(4'h0, v, d);
    n_cmp++;
    if (d !== 32'(exp_shadow)) begin
      n_bad++;
      $display("FAIL mask_readback: got %h exp %h", d, exp_shadow);
    end
    wait_cc(6, seen);
    take(ack, cc, w, ack2);
    exp_cnt++;
    n_cmp++;
    if (!seen || ack !== 1'b1 || w !== exp_shadow) begin
      n_bad++;
      $display("FAIL mask_commit: got seen=%b ack=%b w=%h exp %h",
        seen, ack, w, exp_shadow);
    end
  endtask

  task automatic test_coalesce();
    logic ack, cc, ack2, seen, any;
    logic [16:0] w;
    wr(4'h0, 32'h1);
    wait_cc(6, seen);
    wr(4'h0, 32'h2);
    exp_shadow = 17'h2;
    cyc();
    take(ack, cc, w, ack2);
    exp_cnt++;
    n_cmp++;
    if (!seen || ack !== 1'b1 || w !== 17'h2) begin
      n_bad++;
      $display("FAIL coalesce_commit: got seen=%b ack=%b w=%h exp 00002",
        seen, ack, w);
    end
    any = 1'b0;
    repeat (6) begin
      any |= bus.channel_changed | bus.read_ack;
      cyc();
    end
    n_cmp++;
    if (any !== 1'b0) begin
      n_bad++;
      $display("FAIL coalesce_single: got extra notify=%b exp 0", any);
    end
  endtask

  task automatic test_collide();
    logic ack, cc, ack2, seen;
    logic [16:0] w;
    wr(4'h0, 32'h10001);
    exp_shadow = 17'h10001;
    wait_cc(6, seen);
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = 4'h0;
    bus.reg_wdata = 32'h2;
    bus.read_active_channel = 1'b1;
    cyc();
    bus.reg_wr = 1'b0;
    bus.read_active_channel = 1'b0;
    exp_cnt++;
    n_cmp++;
    if (!seen || bus.read_ack !== 1'b1 ||
        bus.activate_channels !== exp_shadow) begin
      n_bad++;
      $display("FAIL collide_old: got ack=%b w=%h exp 1/%h",
        bus.read_ack, bus.activate_channels, exp_shadow);
    end
    exp_shadow = 17'h2;
    cyc();
    wait_cc(4, seen);
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL collide_renotify: got cc=0 exp 1");
    end
    take(ack, cc, w, ack2);
    exp_cnt++;
    n_cmp++;
    if (ack !== 1'b1 || w !== exp_shadow) begin
      n_bad++;
      $display("FAIL collide_new: got ack=%b w=%h exp %h", ack, w, exp_shadow);
    end
  endtask

  task automatic test_rd_wr_same();
    logic ack, cc, ack2, seen;
    logic [16:0] w;
    bus.reg_rd    = 1'b1;
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = 4'h0;
    bus.reg_wdata = 32'h10002;
    cyc();
    bus.reg_rd = 1'b0;
    bus.reg_wr = 1'b0;
    n_cmp++;
    if (bus.reg_rvalid !== 1'b1 ||
        bus.reg_rdata !== 32'(exp_shadow)) begin
      n_bad++;
      $display("FAIL rdwr_prewrite: got v=%b d=%h exp 1/%h",
        bus.reg_rvalid, bus.reg_rdata, exp_shadow);
    end
    exp_shadow = 17'h10002;
    cyc();
    n_cmp++;
    if (bus.reg_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rvalid_pulse: got %b exp 0", bus.reg_rvalid);
    end
    wait_cc(6, seen);
    take(ack, cc, w, ack2);
    exp_cnt++;
    n_cmp++;
    if (!seen || w !== exp_shadow) begin
      n_bad++;
      $display("FAIL rdwr_commit: got w=%h exp %h", w, exp_shadow);
    end
  endtask

  task automatic test_random();
    logic ack, cc, ack2, seen, v;
    logic [16:0] w;
    logic [31:0] d, r;
    int nw;
    for (int it = 0; it < 24; it++) begin
      nw = int'($urandom_range(1, 3));
      r = $urandom;
      wr(4'h0, r);
      exp_shadow = r[16:0] & MASK;
      wait_cc(6, seen);
      for (int k = 1; k < nw; k++) begin
        repeat ($urandom_range(0, 3)) cyc();
        r = $urandom;
        wr(4'h0, r);
        exp_shadow = r[16:0] & MASK;
      end
      if ($urandom_range(0, 1) == 1) begin
        rd(4'h0, v, d);
        n_cmp++;
        if (d !== 32'(exp_shadow)) begin
          n_bad++;
          $display("FAIL rand_readback[%0d]: got %h exp %h",
            it, d, exp_shadow);
        end
      end
      repeat ($urandom_range(0, 4)) cyc();
      take(ack, cc, w, ack2);
      exp_cnt++;
      n_cmp++;
      if (!seen || ack !== 1'b1 || w !== exp_shadow) begin
        n_bad++;
        $display("FAIL rand_commit[%0d]: got seen=%b ack=%b w=%h exp %h",
          it, seen, ack, w, exp_shadow);
      end
      rd(4'h1, v, d);
      n_cmp++;
      if (d[15:8] !== exp_cnt || d[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_status[%0d]: got %h exp cnt=%h",
          it, d, exp_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    logic ack, cc, ack2, seen, v, any;
    logic [16:0] w;
    logic [31:0] d;
    int n;
    rd(4'h5, v, d);
    n_cmp++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_bad++;
      $display("FAIL unmapped_read: got v=%b d=%h exp 1/0", v, d);
    end
    wr(4'h7, $urandom);
    any = 1'b0;
    repeat (4) begin
      any |= bus.channel_changed;
      cyc();
    end
    rd(4'h0, v, d);
    n_cmp++;
    if (any !== 1'b0 || d !== 32'(exp_shadow)) begin
      n_bad++;
      $display("FAIL unmapped_write: got cc=%b d=%h exp 0/%h",
        any, d, exp_shadow);
    end
    n = 256 - int'(exp_cnt);
    for (int i = 0; i < n; i++) begin
      wr(4'h2, 32'h1);
      wait_cc(6, seen);
      take(ack, cc, w, ack2);
      exp_cnt++;
      n_cmp++;
      if (!seen || ack !== 1'b1 || w !== exp_shadow) begin
        n_bad++;
        $display("FAIL force_commit[%0d]: got ack=%b w=%h exp %h",
          i, ack, w, exp_shadow);
      end
    end
    rd(4'h1, v, d);
    n_cmp++;
    if (d[15:8] !== exp_cnt || d[15:8] !== 8'h00) begin
      n_bad++;
      $display("FAIL cnt_wrap: got %h exp 00", d[15:8]);
    end
  endtask

  task automatic test_timeout();
    logic ack, cc, ack2, seen, v, exp_err;
    logic [16:0] w;
    logic [31:0] d;
`ifdef TDC_CFG_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    wr(4'h2, 32'h1);
    wait_cc(6, seen);
    repeat (TMO / 2) cyc();
    rd(4'h1, v, d);
    n_cmp++;
    if (d[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_early: got %b exp 0", d[1]);
    end
    repeat (TMO + 4) cyc();
    rd(4'h1, v, d);
    n_cmp++;
    if (!seen || d[1] !== exp_err ||
        bus.channel_changed !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_err: got err=%b cc=%b exp %b/1",
        d[1], bus.channel_changed, exp_err);
    end
    wr(4'h2, 32'h2);
    rd(4'h1, v, d);
    n_cmp++;
    if (d[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_clear: got %b exp 0", d[1]);
    end
    take(ack, cc, w, ack2);
    exp_cnt++;
    n_cmp++;
    if (ack !== 1'b1 || w !== exp_shadow) begin
      n_bad++;
      $display("FAIL tmo_commit: got ack=%b w=%h exp %h", ack, w, exp_shadow);
    end
  endtask

  task automatic test_reset_mid();
    logic ack, cc, ack2, seen, v, any;
    logic [16:0] w;
    logic [31:0] d;
    wr(4'h0, 32'h10001);
    wait_cc(6, seen);
    take(ack, cc, w, ack2);
    wr(4'h0, 32'h2);
    wait_cc(6, seen);
    reset = 1'b0;
    bus.read_active_channel = 1'b1;
    cyc();
    bus.read_active_channel = 1'b0;
    n_cmp++;
    if (!seen || {bus.channel_changed, bus.read_ack,
         bus.reg_rvalid, bus.activate_channels} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got cc=%b ack=%b rv=%b act=%h exp all 0",
        bus.channel_changed, bus.read_ack, bus.reg_rvalid,
        bus.activate_channels);
    end
    reset = 1'b1;
    exp_shadow = '0;
    exp_cnt    = '0;
    any = 1'b0;
    repeat (5) begin
      any |= bus.channel_changed | bus.read_ack;
      cyc();
    end
    rd(4'h1, v, d);
    n_cmp++;
    if (any !== 1'b0 || d !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid_idle: got notify=%b status=%h exp 0/0",
        any, d);
    end
  endtask

  initial begin
    bus.reg_wr              = 1'b0;
    bus.reg_rd              = 1'b0;
    bus.reg_addr            = 4'h0;
    bus.reg_wdata           = 32'h0;
    bus.read_active_channel = 1'b0;
    test_reset();
    test_basic();
    test_mask();
    test_coalesce();
    test_collide();
    test_rd_wr_same();
    test_random();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
